// File: rtl/mul_pkg.sv
// mul_pkg: shared types and default widths for the pipelined multiply unit.
//   - MUL_* localparams: default widths used by mul_pipe_unit parameters
//   - mul_stage_t: one pipeline stage payload at the default widths
//   - mul_fsm_e: operand-resolution FSM states
package mul_pkg;

    localparam int MUL_DATA_W     = 32;
    localparam int MUL_NUM_STAGES = 3;
    localparam int MUL_ID_W       = 3;
    localparam int MUL_RD_W       = 5;
    localparam int MUL_PC_W       = 32;

    // valid is the first field, so it lands in the MSB of the packed vector.
    typedef struct packed {
        logic                    valid;
        logic [MUL_ID_W-1:0]     id;
        logic [MUL_PC_W-1:0]     pc;
        logic [MUL_RD_W-1:0]     rd;
        logic                    is_signed;
        logic                    high;
        logic                    xcpt;
        logic [2*MUL_DATA_W-1:0] product;
    } mul_stage_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_WAIT = 1'b1
    } mul_fsm_e;

endpackage

// File: rtl/mul_pipe_stage.sv
// mul_pipe_stage: one register stage of the multiply pipeline.
//   clock, reset (sync, active-high), flush
//   data_i / data_o : W-bit stage payload; bit W-1 is the stage valid bit,
//                     which flush clears while the rest of the payload loads.
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_i;
            if (flush) begin
                data_q[W-1] <= 1'b0;
            end
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: pipelined integer multiply with ROB operand resolution.
//   Decode side : req_* request, src*_data/pend/tag operands, stall_decode
//   ROB side    : src*_rob_id lookup ids, rob*_hit/rob*_data forwarding
//   Writeback   : wb_valid/id/pc/rd/data, wb_xcpt_in, wb_xcpt_ovf
//   Control     : clock, reset (sync, active-high), flush
// Optional feature macro: MUL_HIGH_EN (honour req_high, upper-half result).
// Issue in cycle T gives wb_valid in cycle T+NUM_STAGES: the product is
// formed combinationally at issue, then NUM_STAGES-1 pipe registers, then
// the registered writeback outputs.
module mul_pipe_unit
    import mul_pkg::*;
#(
    parameter int DATA_W     = MUL_DATA_W,
    parameter int NUM_STAGES = MUL_NUM_STAGES,
    parameter int ID_W       = MUL_ID_W,
    parameter int RD_W       = MUL_RD_W,
    parameter int PC_W       = MUL_PC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ID_W-1:0]   req_id,
    input  logic [PC_W-1:0]   req_pc,
    input  logic [RD_W-1:0]   req_rd,
    input  logic              req_signed,
    input  logic              req_high,
    input  logic              req_xcpt,
    input  logic [DATA_W-1:0] src1_data,
    input  logic [DATA_W-1:0] src2_data,
    input  logic              src1_pend,
    input  logic              src2_pend,
    output logic [ID_W-1:0]   src1_rob_id,
    output logic [ID_W-1:0]   src2_rob_id,
    input  logic [ID_W-1:0]   src1_tag,
    input  logic [ID_W-1:0]   src2_tag,
    input  logic              rob1_hit,
    input  logic              rob2_hit,
    input  logic [DATA_W-1:0] rob1_data,
    input  logic [DATA_W-1:0] rob2_data,
    output logic              stall_decode,
    output logic              wb_valid,
    output logic [ID_W-1:0]   wb_id,
    output logic [PC_W-1:0]   wb_pc,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_xcpt_in,
    output logic              wb_xcpt_ovf
);

    typedef struct packed {
        logic                valid;
        logic [ID_W-1:0]     id;
        logic [PC_W-1:0]     pc;
        logic [RD_W-1:0]     rd;
        logic                is_signed;
        logic                high;
        logic                xcpt;
        logic [2*DATA_W-1:0] product;
    } stage_t;

    localparam int SW = $bits(stage_t);

    assign src1_rob_id = src1_tag;
    assign src2_rob_id = src2_tag;

    // ---------------- operand resolution and FSM ----------------
    mul_fsm_e          state_q, state_d;
    logic              found1_q, found1_d, found2_q, found2_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic              res1, res2;
    logic [DATA_W-1:0] live1, live2;
    logic              issue, stall;
    logic [DATA_W-1:0] op_a, op_b;

    assign res1  = !src1_pend | rob1_hit | (src1_tag == req_id);
    assign res2  = !src2_pend | rob2_hit | (src2_tag == req_id);
    assign live1 = (src1_pend && rob1_hit) ? rob1_data : src1_data;
    assign live2 = (src2_pend && rob2_hit) ? rob2_data : src2_data;

    always_comb begin
        state_d  = state_q;
        found1_d = found1_q;
        found2_d = found2_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        issue    = 1'b0;
        stall    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        case (state_q)
            MUL_IDLE: begin
                if (req_valid) begin
                    if (req_xcpt) begin
                        issue = 1'b1;
                    end else if (res1 && res2) begin
                        issue = 1'b1;
                        op_a  = live1;
                        op_b  = live2;
                    end else begin
                        // Already-resolved operands are latched as found so
                        // WAIT only tracks what is still outstanding.
                        stall    = 1'b1;
                        state_d  = MUL_WAIT;
                        found1_d = res1;
                        found2_d = res2;
                        data1_d  = live1;
                        data2_d  = live2;
                    end
                end
            end
            MUL_WAIT: begin
                if ((found1_q || rob1_hit) && (found2_q || rob2_hit)) begin
                    issue    = 1'b1;
                    op_a     = found1_q ? data1_q : rob1_data;
                    op_b     = found2_q ? data2_q : rob2_data;
                    state_d  = MUL_IDLE;
                    found1_d = 1'b0;
                    found2_d = 1'b0;
                end else begin
                    stall = 1'b1;
                    // A repeated hit never overwrites an already latched value.
                    if (rob1_hit && !found1_q) begin
                        found1_d = 1'b1;
                        data1_d  = rob1_data;
                    end
                    if (rob2_hit && !found2_q) begin
                        found2_d = 1'b1;
                        data2_d  = rob2_data;
                    end
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q  <= MUL_IDLE;
            found1_q <= 1'b0;
            found2_q <= 1'b0;
            data1_q  <= '0;
            data2_q  <= '0;
        end else begin
            state_q  <= state_d;
            found1_q <= found1_d;
            found2_q <= found2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
        end
    end

    assign stall_decode = stall;

    // ---------------- stage 0: full-width product ----------------
    logic [2*DATA_W-1:0] ext_a, ext_b;
    stage_t              s0;

    assign ext_a = req_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
    assign ext_b = req_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};

    always_comb begin
        s0           = '0;
        s0.valid     = issue && !flush;
        s0.id        = req_id;
        s0.pc        = req_pc;
        s0.rd        = req_rd;
        s0.is_signed = req_signed;
        s0.high      = req_high;
        s0.xcpt      = req_xcpt;
        s0.product   = ext_a * ext_b;
    end

    // ---------------- register stages ----------------
    logic [SW-1:0] chain [NUM_STAGES];
    stage_t        last;

    assign chain[0] = s0;

    for (genvar k = 0; k < NUM_STAGES - 1; k++) begin : g_stage
        mul_pipe_stage #(.W(SW)) u_stage (
            .clock  (clock),
            .reset  (reset),
            .flush  (flush),
            .data_i (chain[k]),
            .data_o (chain[k+1])
        );
    end

    assign last = chain[NUM_STAGES-1];

    // ---------------- result selection ----------------
    logic [DATA_W-1:0] lo, hi;
    logic              ovf_lo;
    logic [DATA_W-1:0] res_data;
    logic              res_ovf;

    assign lo     = last.product[DATA_W-1:0];
    assign hi     = last.product[2*DATA_W-1:DATA_W];
    assign ovf_lo = last.is_signed ? (hi != {DATA_W{lo[DATA_W-1]}}) : (hi != '0);

`ifdef MUL_HIGH_EN
    assign res_data = last.high ? hi : lo;
    assign res_ovf  = !last.high && ovf_lo && !last.xcpt;
`else
    logic unused_high;
    assign unused_high = last.high;
    assign res_data    = lo;
    assign res_ovf     = ovf_lo && !last.xcpt;
`endif

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wb_valid    <= 1'b0;
            wb_id       <= '0;
            wb_pc       <= '0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_xcpt_in  <= 1'b0;
            wb_xcpt_ovf <= 1'b0;
        end else begin
            wb_valid    <= last.valid;
            wb_id       <= last.id;
            wb_pc       <= last.pc;
            wb_rd       <= last.rd;
            wb_data     <= res_data;
            wb_xcpt_in  <= last.xcpt;
            wb_xcpt_ovf <= res_ovf;
        end
    end

endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb_mul_pipe_unit: directed scoreboard bench for mul_pipe_unit.
module tb_mul_pipe_unit;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int IW = 3;
    localparam int RW = 5;
    localparam int PW = 32;

    logic          clock = 1'b0;
    logic          reset, flush;
    logic          req_valid, req_signed, req_high, req_xcpt;
    logic [IW-1:0] req_id;
    logic [PW-1:0] req_pc;
    logic [RW-1:0] req_rd;
    logic [DW-1:0] src1_data, src2_data, rob1_data, rob2_data;
    logic          src1_pend, src2_pend, rob1_hit, rob2_hit;
    logic [IW-1:0] src1_tag, src2_tag, src1_rob_id, src2_rob_id;
    logic          stall_decode, wb_valid, wb_xcpt_in, wb_xcpt_ovf;
    logic [IW-1:0] wb_id;
    logic [PW-1:0] wb_pc;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    mul_pipe_unit #(
        .DATA_W(DW), .NUM_STAGES(NS), .ID_W(IW), .RD_W(RW), .PC_W(PW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_id(req_id), .req_pc(req_pc), .req_rd(req_rd),
        .req_signed(req_signed), .req_high(req_high), .req_xcpt(req_xcpt),
        .src1_data(src1_data), .src2_data(src2_data),
        .src1_pend(src1_pend), .src2_pend(src2_pend),
        .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .rob1_hit(rob1_hit), .rob2_hit(rob2_hit),
        .rob1_data(rob1_data), .rob2_data(rob2_data),
        .stall_decode(stall_decode),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_xcpt_in(wb_xcpt_in), .wb_xcpt_ovf(wb_xcpt_ovf)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [IW-1:0] id;
        logic [PW-1:0] pc;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic          xi;
        logic          ovf;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pc_of(input logic [IW-1:0] id);
        return 32'h1000 + 32'(id) * 32'd4;
    endfunction

    function automatic logic [RW-1:0] rd_of(input logic [IW-1:0] id);
        return 5'(id) + 5'd1;
    endfunction

    // Reference: signed overflow judged by range of the exact 64-bit product.
    task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sgn,
                         output logic [DW-1:0] d, output logic o);
        longint sa, sbv, sp;
        logic [63:0] up;
        if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            sp  = sa * sbv;
            up  = 64'(sp);
            o   = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end else begin
            up = {32'h0, a} * {32'h0, b};
            o  = up > 64'h0000_0000_FFFF_FFFF;
        end
        d = up[31:0];
    endtask

    task automatic push(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic xi, input logic o);
        exp_t e;
        e.id = id; e.pc = pc_of(id); e.rd = rd_of(id);
        e.data = d; e.xi = xi; e.ovf = o; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_id = '0; req_pc = '0; req_rd = '0;
        req_signed = 0; req_high = 0; req_xcpt = 0;
        src1_data = '0; src2_data = '0; src1_pend = 0; src2_pend = 0;
        src1_tag = '0; src2_tag = '0;
        rob1_hit = 0; rob2_hit = 0; rob1_data = '0; rob2_data = '0;
    endtask

    task automatic present(input logic [IW-1:0] id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic sgn, input logic hi, input logic xi);
        idle_inputs();
        req_valid = 1; req_id = id; req_pc = pc_of(id); req_rd = rd_of(id);
        req_signed = sgn; req_high = hi; req_xcpt = xi;
        src1_data = a; src2_data = b;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        @(negedge clock);
        chk(tag, stall_decode, exp);
    endtask

    // Writeback monitor: every wb_valid must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", wb_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_id",   wb_id,       e.id);
                chk("wb_pc",   wb_pc,       e.pc);
                chk("wb_rd",   wb_rd,       e.rd);
                chk("wb_data", wb_data,     e.data);
                chk("wb_xin",  wb_xcpt_in,  e.xi);
                chk("wb_ovf",  wb_xcpt_ovf, e.ovf);
                chk("wb_lat",  cyc,         e.cyc + NS);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ra, rb, ed;
        logic          rs, eo;

        idle_inputs();
        reset = 1; flush = 0;
        step(); step();
        @(negedge clock);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data",  wb_data, 0);
        chk("rst_wb_id",    wb_id, 0);
        chk("rst_wb_pc",    wb_pc, 0);
        chk("rst_wb_ovf",   wb_xcpt_ovf, 0);
        chk("rst_stall",    stall_decode, 0);
        step();
        reset = 0;
        step();

        // Plain issues, no pending operands.
        present(3'd1, 32'h0000_FFFF, 32'h0001_0001, 0, 0, 0); push(3'd1, 32'hFFFF_FFFF, 0, 0);
        chk_stall("stall_u1", 0); step();
        present(3'd2, 32'hFFFF_FFFE, 32'h3, 1, 0, 0); push(3'd2, 32'hFFFF_FFFA, 0, 0);
        chk_stall("stall_s1", 0); step();
        present(3'd3, 32'h8000_0000, 32'h2, 0, 0, 0); push(3'd3, 32'h0, 0, 1);
        chk_stall("stall_u2", 0); step();
        present(3'd4, 32'h8000_0000, 32'h2, 0, 1, 0);
`ifdef MUL_HIGH_EN
        push(3'd4, 32'h1, 0, 0);
`else
        push(3'd4, 32'h0, 0, 1);
`endif
        chk_stall("stall_hi", 0); step();
        present(3'd5, 32'h4000_0000, 32'h2, 1, 0, 0); push(3'd5, 32'h8000_0000, 0, 1);
        chk_stall("stall_s2", 0); step();
        idle_inputs();
        repeat (5) step();

        // src1 pending, hit two cycles later.
        present(3'd1, 32'd99, 32'd6, 0, 0, 0); src1_pend = 1; src1_tag = 3'd5;
        chk_stall("pend1_c0", 1);
        chk("src1_rob_id", src1_rob_id, 3'd5);
        step();
        chk_stall("pend1_c1", 1); step();
        rob1_hit = 1; rob1_data = 32'd7; push(3'd1, 32'd42, 0, 0);
        chk_stall("pend1_c2", 0); step();
        idle_inputs();
        repeat (5) step();

        // Both pending, hits on different cycles; repeated hit must not overwrite.
        present(3'd2, 32'd11, 32'd12, 0, 0, 0); src1_pend = 1; src2_pend = 1; src1_tag = 3'd3; src2_tag = 3'd4;
        chk_stall("pend2_c0", 1);
        chk("src2_rob_id", src2_rob_id, 3'd4);
        step();
        rob1_hit = 1; rob1_data = 32'd5;
        chk_stall("pend2_c1", 1); step();
        rob1_data = 32'd77; rob2_hit = 1; rob2_data = 32'd9; push(3'd2, 32'd45, 0, 0);
        chk_stall("pend2_c2", 0); step();
        idle_inputs();
        repeat (5) step();

        // Pending but hit in the same cycle, and pending with tag equal to own id.
        present(3'd3, 32'd0, 32'd8, 0, 0, 0); src1_pend = 1; src1_tag = 3'd6; rob1_hit = 1; rob1_data = 32'd3;
        push(3'd3, 32'd24, 0, 0);
        chk_stall("hit_same", 0); step();
        present(3'd6, 32'd4, 32'd5, 0, 0, 0); src1_pend = 1; src1_tag = 3'd6;
        push(3'd6, 32'd20, 0, 0);
        chk_stall("tag_self", 0); step();

        // Upstream exception with pending operands: no stall, zero operands, no overflow.
        present(3'd4, 32'h8000_0000, 32'h2, 0, 0, 1); src1_pend = 1; src2_pend = 1; src1_tag = 3'd1; src2_tag = 3'd2;
        push(3'd4, 32'h0, 1, 0);
        chk_stall("xcpt_nostall", 0); step();
        idle_inputs();
        repeat (5) step();

        // Back-to-back issues with flush when the first reaches writeback.
        present(3'd5, 32'd3, 32'd4, 0, 0, 0); push(3'd5, 32'd12, 0, 0); step();
        present(3'd6, 32'd5, 32'd6, 0, 0, 0); push(3'd6, 32'd30, 0, 0); step();
        present(3'd7, 32'd7, 32'd8, 0, 0, 0); push(3'd7, 32'd56, 0, 0); step();
        present(3'd0, 32'd9, 32'd9, 0, 0, 0); flush = 1; step();
        flush = 0; idle_inputs();
        chk("flush_dropped", sb.size(), 2);
        sb.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("wb_after_flush", wb_valid, 0);
            step();
        end
        present(3'd1, 32'd2, 32'd3, 0, 0, 0); push(3'd1, 32'd6, 0, 0);
        chk_stall("post_flush_idle", 0); step();
        idle_inputs();
        repeat (5) step();

        // Flush while waiting, with a simultaneous hit: nothing issues, FSM back to IDLE.
        present(3'd2, 32'd1, 32'd1, 0, 0, 0); src1_pend = 1; src1_tag = 3'd7;
        chk_stall("fw_c0", 1); step();
        flush = 1; rob1_hit = 1; rob1_data = 32'd1; step();
        flush = 0; idle_inputs();
        chk_stall("fw_idle", 0); step();
        repeat (5) step();

        // Reset while waiting behaves the same.
        present(3'd3, 32'd1, 32'd1, 0, 0, 0); src2_pend = 1; src2_tag = 3'd0;
        chk_stall("rw_c0", 1); step();
        reset = 1; step();
        reset = 0; idle_inputs();
        chk_stall("rw_idle", 0); step();

        // Randomised back-to-back stream.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            present(3'(i), ra, rb, rs, 0, 0);
            model(ra, rb, rs, ed, eo);
            push(3'(i), ed, 0, eo);
            step();
        end
        idle_inputs();
        repeat (NS + 3) step();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
